timer_preset_loader: RTL and testbench

Keypad-side writer for the BCD down-counter chain of the kitchen timer. It collects digit keystrokes into a 3-digit M:SS preset (minute units, second tens, second units) and validates it on start. It then drives the counters' synchronous load interface with one load cycle, and holds count-enable until the chain reports zero. It sits between keypad decode and the mod10/mod6/mod10 counter chain.

---
 rtl/timer_preset_loader.sv | 113 +++++++++++
 tb/tb_timer_preset_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_preset_loader.sv
// Keypad-side preset loader for the kitchen timer's BCD down-counter chain.
// Collects up to three digits as M:SS, validates on start, then pulses loadn once and enables counting.
module timer_preset_loader (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       cancel,
    input  logic       timer_zero,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       loadn,
    output logic       en,
    output logic [1:0] digit_count,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [3:0] sec_ones_n, sec_tens_n, min_ones_n;
    logic [1:0] digit_count_n;
    logic       error_n;
    logic       preset_zero;

    assign preset_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (min_ones == 4'd0);

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        sec_ones_n    = sec_ones;
        sec_tens_n    = sec_tens;
        min_ones_n    = min_ones;
        digit_count_n = digit_count;
        error_n       = 1'b0;

        if (cancel) begin
            state_n       = IDLE;
            sec_ones_n    = 4'd0;
            sec_tens_n    = 4'd0;
            min_ones_n    = 4'd0;
            digit_count_n = 2'd0;
        end else begin
            unique case (state)
                IDLE, ENTRY: begin
                    // start outranks key_valid; a key arriving with start is dropped silently
                    if (start) begin
                        if (state == IDLE || sec_tens > 4'd5 || preset_zero)
                            error_n = 1'b1;
                        else
                            state_n = LOAD;
                    end else if (key_valid) begin
                        if (key_digit <= 4'd9 && digit_count != 2'd3) begin
                            min_ones_n    = sec_tens;
                            sec_tens_n    = sec_ones;
                            sec_ones_n    = key_digit;
                            digit_count_n = digit_count + 2'd1;
                            state_n       = ENTRY;
                        end else begin
                            error_n = 1'b1;
                        end
                    end
                end
                LOAD: state_n = RUN;
                RUN: begin
                    if (timer_zero) begin
                        state_n       = IDLE;
                        sec_ones_n    = 4'd0;
                        sec_tens_n    = 4'd0;
                        min_ones_n    = 4'd0;
                        digit_count_n = 2'd0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            sec_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            min_ones    <= 4'd0;
            digit_count <= 2'd0;
            loadn       <= 1'b1;
            en          <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            sec_ones    <= sec_ones_n;
            sec_tens    <= sec_tens_n;
            min_ones    <= min_ones_n;
            digit_count <= digit_count_n;
            loadn       <= (state_n != LOAD);
            en          <= (state_n == RUN);
            error       <= error_n;
            busy        <= (state_n == LOAD) || (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_timer_preset_loader.sv
// Directed bench for timer_preset_loader: entry, validation, load/run sequencing, priority and async clear.
// Observed vector layout: {min_ones, sec_tens, sec_ones, digit_count, loadn, en, error, busy}.
module tb_timer_preset_loader;

    logic       clock = 1'b0;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       cancel;
    logic       timer_zero;
    logic [3:0] sec_ones, sec_tens, min_ones;
    logic       loadn, en, error, busy;
    logic [1:0] digit_count;

    int tests  = 0;
    int failed = 0;

    timer_preset_loader dut (
        .clock       (clock),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .cancel      (cancel),
        .timer_zero  (timer_zero),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .loadn       (loadn),
        .en          (en),
        .digit_count (digit_count),
        .error       (error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] obs();
        return {min_ones, sec_tens, sec_ones, digit_count, loadn, en, error, busy};
    endfunction

    function automatic logic [17:0] expv(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                                         input logic [1:0] c, input logic ld, input logic e,
                                         input logic er, input logic b);
        return {m, t, o, c, ld, e, er, b};
    endfunction

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        clear = 1'b1;
        #3;
        tests++;
        e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL reset_values: got %h expected %h", obs(), e); end
        @(negedge clock);
        clear = 1'b0;
        tick();
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL idle_after_reset: got %h expected %h", obs(), e); end
    endtask

    task automatic test_load_run();
        logic [17:0] e;
        press(1);
        tests++; e = expv(0, 0, 1, 1, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL key1: got %h expected %h", obs(), e); end
        press(3);
        tests++; e = expv(0, 1, 3, 2, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL key3: got %h expected %h", obs(), e); end
        press(0);
        tests++; e = expv(1, 3, 0, 3, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL key0: got %h expected %h", obs(), e); end
        do_start();
        tests++; e = expv(1, 3, 0, 3, 0, 0, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL load_cycle: got %h expected %h", obs(), e); end
        tick();
        tests++; e = expv(1, 3, 0, 3, 1, 1, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL run_first: got %h expected %h", obs(), e); end
        // start in RUN is ignored and must not re-pulse loadn
        do_start();
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL run_hold: got %h expected %h", obs(), e); end
        do_cancel();
        tests++; e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL cancel_run: got %h expected %h", obs(), e); end
    endtask

    task automatic test_bad_start();
        logic [17:0] e;
        press(9); press(9); press(9);
        do_start();
        tests++; e = expv(9, 9, 9, 3, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL start_999: got %h expected %h", obs(), e); end
        tick();
        tests++; e = expv(9, 9, 9, 3, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL error_one_cycle: got %h expected %h", obs(), e); end
        do_cancel();
        tests++; e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL cancel_entry: got %h expected %h", obs(), e); end
        // sec_tens 6 rejected, 5 accepted, all-zero preset rejected
        press(6); press(0);
        do_start();
        tests++; e = expv(0, 6, 0, 2, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL start_tens6: got %h expected %h", obs(), e); end
        do_cancel();
        press(5); press(9);
        do_start();
        tests++; e = expv(0, 5, 9, 2, 0, 0, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL start_tens5: got %h expected %h", obs(), e); end
        do_cancel();
        press(0);
        do_start();
        tests++; e = expv(0, 0, 0, 1, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL start_zero_preset: got %h expected %h", obs(), e); end
        do_cancel();
    endtask

    task automatic test_overflow();
        logic [17:0] e;
        press(1); press(2); press(3);
        press(4);
        tests++; e = expv(1, 2, 3, 3, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL fourth_key: got %h expected %h", obs(), e); end
        press(12);
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL key12_full: got %h expected %h", obs(), e); end
        do_cancel();
        press(5);
        press(12);
        tests++; e = expv(0, 0, 5, 1, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL key12_partial: got %h expected %h", obs(), e); end
        press(15);
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL key15_partial: got %h expected %h", obs(), e); end
        do_cancel();
    endtask

    task automatic test_timer_zero();
        logic [17:0] e;
        press(0); press(5);
        do_start();
        // timer_zero high during LOAD must be ignored
        timer_zero = 1'b1;
        tick();
        tests++; e = expv(0, 0, 5, 2, 1, 1, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL tz_ignored_in_load: got %h expected %h", obs(), e); end
        tick();
        timer_zero = 1'b0;
        tests++; e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL tz_to_idle: got %h expected %h", obs(), e); end
        do_start();
        tests++; e = expv(0, 0, 0, 0, 1, 0, 1, 0);
        if (obs() !== e) begin failed++; $display("FAIL start_idle: got %h expected %h", obs(), e); end
    endtask

    task automatic test_priority();
        logic [17:0] e;
        press(3);
        key_valid = 1'b1; key_digit = 4'd5; start = 1'b1;
        tick();
        key_valid = 1'b0; start = 1'b0;
        tests++; e = expv(0, 0, 3, 1, 0, 0, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL start_over_key: got %h expected %h", obs(), e); end
        tick();
        tests++; e = expv(0, 0, 3, 1, 1, 1, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL start_over_key_run: got %h expected %h", obs(), e); end
        do_cancel();
        press(3);
        cancel = 1'b1; start = 1'b1;
        tick();
        cancel = 1'b0; start = 1'b0;
        tests++; e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL cancel_over_start: got %h expected %h", obs(), e); end
        tick();
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL no_load_after_cancel: got %h expected %h", obs(), e); end
    endtask

    task automatic test_async_clear();
        logic [17:0] e;
        press(1); press(0);
        do_start();
        tests++; e = expv(0, 1, 0, 2, 0, 0, 0, 1);
        if (obs() !== e) begin failed++; $display("FAIL load_before_clear: got %h expected %h", obs(), e); end
        #2 clear = 1'b1;
        #1;
        tests++; e = expv(0, 0, 0, 0, 1, 0, 0, 0);
        if (obs() !== e) begin failed++; $display("FAIL async_clear_load: got %h expected %h", obs(), e); end
        @(negedge clock);
        clear = 1'b0;
        press(2); press(0);
        do_start();
        tick();
        #2 clear = 1'b1;
        #1;
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL async_clear_run: got %h expected %h", obs(), e); end
        @(negedge clock);
        clear = 1'b0;
        tick();
    endtask

    initial begin
        clear      = 1'b0;
        key_valid  = 1'b0;
        key_digit  = 4'd0;
        start      = 1'b0;
        cancel     = 1'b0;
        timer_zero = 1'b0;
        test_reset();
        test_load_run();
        test_bad_start();
        test_overflow();
        test_timer_zero();
        test_priority();
        test_async_clear();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
